// File: rtl/dram_port_arbiter_pkg.sv
// dram_port_arbiter_pkg: access sequencer states, default widths and port ids
package dram_port_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;
  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 8;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_UART = 1'b1;
endpackage

// File: rtl/dram_port_arbiter_rr_arb2.sv
// dram_port_arbiter_rr_arb2: two-way arbiter, round-robin or fixed port-0 priority
module dram_port_arbiter_rr_arb2
  import dram_port_arbiter_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       win,
  output logic       any
);
  logic pri;
  // pri names the port that wins the next tie: the one not granted last
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pri <= PORT_CPU;
    else if (upd) pri <= ~upd_id;
  always_comb begin
    any = |req;
    win = (&req) ? (FIXED_PRI ? PORT_CPU : pri) : req[1];
  end
endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares the byte-wide image DRAM between the CPU and UART ports
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int READ_LAT  = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              dram_we,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_din,
  input  logic [DATA_W-1:0] dram_dout,
  output logic              busy
);
  localparam logic [1:0] CNT_LAST = 2'(READ_LAT > 1 ? READ_LAT - 2 : 0);
  state_t state, state_nx;
  logic sel, we_q, win, any, issue, ret;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q, rd0_q, rd1_q;
  logic [1:0] cnt;
  dram_port_arbiter_rr_arb2 #(.FIXED_PRI(FIXED_PRI != 0)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req({p1_req, p0_req}),
    .upd(issue),
    .upd_id(sel),
    .win(win),
    .any(any)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state == S_WAIT) ? cnt + 2'd1 : 2'd0;
    end
  // only the winner's request is captured; the loser simply keeps asking
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel <= PORT_CPU;
      we_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
    end else if (state == S_IDLE && any) begin
      sel <= win;
      we_q <= win ? p1_we : p0_we;
      addr_q <= win ? p1_addr : p0_addr;
      din_q <= win ? p1_wdata : p0_wdata;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else if (ret) begin
      if (sel) rd1_q <= dram_dout;
      else rd0_q <= dram_dout;
    end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = any ? S_ISSUE : S_IDLE;
      S_ISSUE:  state_nx = we_q ? S_IDLE : (READ_LAT > 1 ? S_WAIT : S_RETURN);
      S_WAIT:   state_nx = (cnt == CNT_LAST) ? S_RETURN : S_WAIT;
      S_RETURN: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end
  // read data is forwarded straight from the DRAM in RETURN so rvalid and rdata coincide
  always_comb begin
    issue = state == S_ISSUE;
    ret = state == S_RETURN;
    p0_gnt = issue && !sel;
    p1_gnt = issue && sel;
    p0_rvalid = ret && !sel;
    p1_rvalid = ret && sel;
    p0_rdata = p0_rvalid ? dram_dout : rd0_q;
    p1_rdata = p1_rvalid ? dram_dout : rd1_q;
    dram_we = issue && we_q;
    dram_addr = addr_q;
    dram_din = din_q;
    busy = state != S_IDLE;
  end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: three arbiter configs (RR lat1, RR lat3, fixed-pri lat1) against a scoreboard
module tb_dram_port_arbiter;
  localparam int NI = 3;
  localparam int NRND = 3000;
  typedef struct {bit rv; int cyc; logic we; logic [16:0] addr; logic [7:0] data;} exp_t;
  logic clk = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic rst_n [NI];
  logic req [NI][2];
  logic we [NI][2];
  logic gnt [NI][2];
  logic rvalid [NI][2];
  logic [16:0] addr [NI][2];
  logic [7:0] wdata [NI][2];
  logic [7:0] rdata [NI][2];
  logic dwe [NI];
  logic busy [NI];
  logic [16:0] daddr [NI];
  logic [7:0] ddin [NI];
  logic [7:0] ddout [NI];
  exp_t sbq [NI*2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NI; k++) begin : gi
    logic [7:0] mem [0:(1<<17)-1];
    logic [7:0] pipe [3];
    dram_port_arbiter #(.ADDR_W(17), .DATA_W(8), .READ_LAT(k == 1 ? 3 : 1), .FIXED_PRI(k == 2 ? 1 : 0)) u_dut (
      .clk(clk), .rst_n(rst_n[k]),
      .p0_req(req[k][0]), .p0_we(we[k][0]), .p0_addr(addr[k][0]), .p0_wdata(wdata[k][0]),
      .p0_gnt(gnt[k][0]), .p0_rvalid(rvalid[k][0]), .p0_rdata(rdata[k][0]),
      .p1_req(req[k][1]), .p1_we(we[k][1]), .p1_addr(addr[k][1]), .p1_wdata(wdata[k][1]),
      .p1_gnt(gnt[k][1]), .p1_rvalid(rvalid[k][1]), .p1_rdata(rdata[k][1]),
      .dram_we(dwe[k]), .dram_addr(daddr[k]), .dram_din(ddin[k]), .dram_dout(ddout[k]), .busy(busy[k])
    );
    // BRAM model: registered read, extra pipeline stages for the longer latency
    always @(posedge clk) begin
      if (dwe[k]) mem[daddr[k]] <= ddin[k];
      pipe[0] <= mem[daddr[k]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ddout[k] = pipe[k == 1 ? 2 : 0];
  end

  function automatic int lat(int k);
    return k == 1 ? 3 : 1;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_ev(string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got pulse, expected none", nm);
  endfunction

  function automatic void push(int k, int p, bit rv, int c, logic w, logic [16:0] a, logic [7:0] d);
    exp_t e;
    e.rv = rv;
    e.cyc = c;
    e.we = w;
    e.addr = a;
    e.data = d;
    sbq[k*2+p].push_back(e);
  endfunction

  function automatic void pop_chk(int k, int p, bit rv);
    exp_t e;
    string nm = $sformatf("u%0d p%0d %s", k, p, rv ? "rvalid" : "gnt");
    if (sbq[k*2+p].size() == 0 || sbq[k*2+p][0].rv != rv) begin
      fail_ev({nm, " unexpected"});
      return;
    end
    e = sbq[k*2+p].pop_front();
    if (e.cyc >= 0) chk({nm, " cycle"}, 64'(cyc), 64'(e.cyc));
    if (rv) chk({nm, " rdata"}, 64'(rdata[k][p]), 64'(e.data));
    else chk({nm, " busy/we/addr/din"}, 64'({busy[k], dwe[k], daddr[k], e.we ? ddin[k] : 8'h00}),
             64'({1'b1, e.we, e.addr, e.we ? e.data : 8'h00}));
  endfunction

  // monitor: every gnt/rvalid pulse must match the head of its port's queue
  always @(negedge clk)
    for (int k = 0; k < NI; k++) begin
      if (dwe[k] && !gnt[k][0] && !gnt[k][1]) fail_ev($sformatf("u%0d dram_we outside gnt", k));
      if (gnt[k][0] && gnt[k][1]) fail_ev($sformatf("u%0d double gnt", k));
      for (int p = 0; p < 2; p++) begin
        if (gnt[k][p]) pop_chk(k, p, 1'b0);
        if (rvalid[k][p]) pop_chk(k, p, 1'b1);
      end
    end

  task automatic idle_wait(int k);
    int n = 0;
    @(negedge clk);
    while (busy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // single access from an idle arbiter: gnt one cycle after the sampling edge, rvalid READ_LAT later
  task automatic access(int k, int p, logic w, logic [16:0] a, logic [7:0] d);
    int n = 0;
    idle_wait(k);
    push(k, p, 1'b0, cyc + 1, w, a, d);
    if (!w) push(k, p, 1'b1, cyc + 1 + lat(k), 1'b0, a, d);
    req[k][p] = 1'b1;
    we[k][p] = w;
    addr[k][p] = a;
    wdata[k][p] = w ? d : ~d;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[k][p] && n < 50);
    chk($sformatf("u%0d p%0d gnt arrives", k, p), 64'(gnt[k][p]), 64'd1);
    req[k][p] = 1'b0;
    if (!w) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rvalid[k][p] && n < 20);
      chk($sformatf("u%0d p%0d rvalid arrives", k, p), 64'(rvalid[k][p]), 64'd1);
    end
  endtask

  task automatic reset_inst(int k);
    @(negedge clk);
    rst_n[k] = 1'b0;
    @(negedge clk);
    rst_n[k] = 1'b1;
  endtask

  task automatic both_reads(int k, logic [16:0] a0, logic [16:0] a1);
    req[k][0] = 1'b1;
    req[k][1] = 1'b1;
    we[k][0] = 1'b0;
    we[k][1] = 1'b0;
    addr[k][0] = a0;
    addr[k][1] = a1;
  endtask

  initial begin
    int t, n, g;
    int ps [2];
    int ri;
    logic rw;
    logic [7:0] rd;
    logic [16:0] ra;
    logic [7:0] rm [2][16];
    bit wr [2][16];
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0;
        we[k][p] = 1'b0;
        addr[k][p] = '0;
        wdata[k][p] = '0;
      end
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < NI; k++)
      chk($sformatf("u%0d idle outputs", k),
          64'({busy[k], dwe[k], daddr[k], ddin[k], gnt[k][0], gnt[k][1], rvalid[k][0], rvalid[k][1], rdata[k][0], rdata[k][1]}), 64'd0);
    // basic write/read per port, data preloads for the later tests
    access(0, 0, 1'b1, 17'h1ABCD, 8'h5A);
    access(0, 0, 1'b0, 17'h1ABCD, 8'h5A);
    access(0, 1, 1'b1, 17'h1ABCE, 8'h3C);
    access(0, 1, 1'b0, 17'h1ABCE, 8'h3C);
    repeat (3) @(negedge clk);
    chk("u0 rdata held", 64'({rdata[0][0], rdata[0][1]}), 64'h5A3C);
    access(0, 0, 1'b1, 17'h00100, 8'h11);
    access(0, 1, 1'b1, 17'h00101, 8'h22);
    access(1, 0, 1'b1, 17'h00010, 8'hC3);
    access(1, 1, 1'b0, 17'h00010, 8'hC3);
    chk("u1 p0_rdata untouched", 64'(rdata[1][0]), 64'd0);
    access(2, 0, 1'b1, 17'h00100, 8'h11);
    access(2, 1, 1'b1, 17'h00101, 8'h22);
    // round-robin: both held, grants alternate 0,1,0,1 every 3 cycles
    reset_inst(0);
    idle_wait(0);
    t = cyc;
    for (int i = 0; i < 2; i++) begin
      push(0, 0, 1'b0, t + 1 + 6*i, 1'b0, 17'h00100, 8'h00);
      push(0, 0, 1'b1, t + 2 + 6*i, 1'b0, 17'h00100, 8'h11);
      push(0, 1, 1'b0, t + 4 + 6*i, 1'b0, 17'h00101, 8'h00);
      push(0, 1, 1'b1, t + 5 + 6*i, 1'b0, 17'h00101, 8'h22);
    end
    both_reads(0, 17'h00100, 17'h00101);
    n = 0;
    g = 0;
    while (g < 4 && n < 40) begin
      @(negedge clk);
      n++;
      g += int'(gnt[0][0]) + int'(gnt[0][1]);
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    chk("u0 rr grant count", 64'(g), 64'd4);
    repeat (4) @(negedge clk);
    // fixed priority: port 0 wins every tie, port 1 only after port 0 lets go
    idle_wait(2);
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      push(2, 0, 1'b0, t + 1 + 3*i, 1'b0, 17'h00100, 8'h00);
      push(2, 0, 1'b1, t + 2 + 3*i, 1'b0, 17'h00100, 8'h11);
    end
    push(2, 1, 1'b0, t + 13, 1'b0, 17'h00101, 8'h00);
    push(2, 1, 1'b1, t + 14, 1'b0, 17'h00101, 8'h22);
    both_reads(2, 17'h00100, 17'h00101);
    n = 0;
    g = 0;
    while (g < 4 && n < 40) begin
      @(negedge clk);
      n++;
      g += int'(gnt[2][0]);
    end
    req[2][0] = 1'b0;
    chk("u2 fixed p0 grant count", 64'(g), 64'd4);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[2][1] && n < 20);
    req[2][1] = 1'b0;
    chk("u2 p1 granted after p0 drops", 64'(gnt[2][1]), 64'd1);
    repeat (3) @(negedge clk);
    // async reset in the WAIT of a port-1 read: outputs clear, read is dropped
    idle_wait(1);
    t = cyc;
    push(1, 1, 1'b0, t + 1, 1'b0, 17'h00010, 8'h00);
    req[1][1] = 1'b1;
    we[1][1] = 1'b0;
    addr[1][1] = 17'h00010;
    @(negedge clk);
    req[1][1] = 1'b0;
    @(negedge clk);
    chk("u1 in wait before reset", 64'({busy[1], rdata[1][1]}), 64'h1C3);
    rst_n[1] = 1'b0;
    #1;
    chk("u1 outputs in reset",
        64'({busy[1], dwe[1], daddr[1], ddin[1], gnt[1][0], gnt[1][1], rvalid[1][0], rvalid[1][1], rdata[1][0], rdata[1][1]}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (8) @(negedge clk);
    t = cyc;
    push(1, 0, 1'b0, t + 1, 1'b0, 17'h00010, 8'h00);
    push(1, 0, 1'b1, t + 4, 1'b0, 17'h00010, 8'hC3);
    push(1, 1, 1'b0, t + 6, 1'b0, 17'h00010, 8'h00);
    push(1, 1, 1'b1, t + 9, 1'b0, 17'h00010, 8'hC3);
    both_reads(1, 17'h00010, 17'h00010);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[1][0] && n < 20);
    req[1][0] = 1'b0;
    chk("u1 tie after reset goes to p0", 64'(gnt[1][0]), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[1][1] && n < 20);
    req[1][1] = 1'b0;
    chk("u1 p1 follows", 64'(gnt[1][1]), 64'd1);
    repeat (6) @(negedge clk);
    // random mixed traffic on u0; ports use disjoint addresses so each has its own reference memory
    ps[0] = 0;
    ps[1] = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++) wr[p][i] = 1'b0;
    t = 0;
    n = 0;
    while ((t < NRND || ps[0] != 0 || ps[1] != 0) && n < 40000) begin
      @(negedge clk);
      n++;
      for (int p = 0; p < 2; p++) begin
        if (ps[p] == 1 && gnt[0][p]) begin
          req[0][p] = 1'b0;
          ps[p] = we[0][p] ? 0 : 2;
        end else if (ps[p] == 2 && rvalid[0][p]) begin
          ps[p] = 0;
        end else if (ps[p] == 0 && t < NRND && $urandom_range(3) != 0) begin
          ri = $urandom_range(15);
          rw = !wr[p][ri] || ($urandom_range(1) == 1);
          rd = 8'($urandom);
          ra = 17'(32'h400 + 2*ri + p);
          if (rw) begin
            rm[p][ri] = rd;
            wr[p][ri] = 1'b1;
          end
          push(0, p, 1'b0, -1, rw, ra, rw ? rd : 8'h00);
          if (!rw) push(0, p, 1'b1, -1, 1'b0, ra, rm[p][ri]);
          req[0][p] = 1'b1;
          we[0][p] = rw;
          addr[0][p] = ra;
          wdata[0][p] = rw ? rd : ~rd;
          ps[p] = 1;
          t++;
        end
      end
    end
    chk("u0 random traffic drained", 64'({ps[0] != 0, ps[1] != 0}), 64'd0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < NI*2; i++) chk($sformatf("scoreboard %0d empty", i), 64'(sbq[i].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
